serial_add_sub_unit: RTL and testbench
======================================

// Module: serial_add_sub_unit
// PURPOSE
//   Parametrised two's-complement add/subtract unit computing DIGIT bits per clock.
//   Operands are accepted over a valid/ready handshake, processed LSB-digit first
//   over WIDTH/DIGIT cycles, and the result is held until the consumer takes it.
//   Successor to the 4-bit ripple add/sub: wider, pipelined in time, with flow control and flags.
// PARAMETERS
//   WIDTH  16  operand/result width in bits; >= 2
//   DIGIT  4   bits processed per RUN cycle; 1 <= DIGIT <= WIDTH; WIDTH % DIGIT == 0
// PORTS
//   clk        in   1      single clock, all state on rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      lhs/rhs/op valid
//   in_ready   out  1      unit can accept operands (high only in IDLE)
//   op         in   1      0 = lhs + rhs, 1 = lhs - rhs
//   lhs        in   WIDTH  left operand, two's complement
//   rhs        in   WIDTH  right operand, two's complement
//   out_valid  out  1      result/flags valid (high only in DONE)
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  result, modulo 2^WIDTH
//   cout       out  1      carry out of MSB (sub: 1 = no borrow, i.e. lhs >= rhs unsigned)
//   overflow   out  1      signed overflow = carry into MSB XOR carry out of MSB
//   zero       out  1      sum == 0
// BEHAVIOUR
//   - Reset (async, rst_n low): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0,
//     overflow=0, zero=0, digit counter=0, internal carry=0. Any in-flight op discarded.
//   - N = WIDTH/DIGIT. FSM states IDLE -> RUN -> DONE -> IDLE.
//   - IDLE: in_ready=1. On edge with in_valid&&in_ready: latch lhs, rhs XOR {WIDTH{op}},
//     carry <= op, counter <= 0, state <= RUN. Inputs ignored when in_valid=0.
//   - RUN: in_ready=0. Each edge adds digit[counter] of lhs, inverted-rhs and carry;
//     writes DIGIT result bits, updates carry, counter++. On the edge processing digit N-1:
//     capture carry-into-MSB and carry-out, compute cout/overflow/zero, state <= DONE.
//   - Latency: out_valid rises exactly N cycles after the accepting edge (N=4 at defaults).
//     DIGIT=WIDTH gives 1 RUN cycle.
//   - DONE: out_valid=1; sum/cout/overflow/zero stable and unchanged while out_ready=0
//     (indefinite stall allowed). On edge with out_valid&&out_ready: out_valid <= 0,
//     state <= IDLE. in_ready is high the following cycle; no same-cycle accept in DONE.
//   - Max throughput: one op per N+2 cycles.
//   - Outputs sum/flags hold last result in IDLE and during RUN until overwritten at DONE
//     entry; consumers sample only when out_valid=1.
//   - Inputs lhs/rhs/op may change freely after the accept edge.
//   - op=1 with rhs = most-negative value: overflow set iff lhs >= 0 (e.g. 0-(-32768)).
//   - Reset asserted during RUN or DONE: immediate return to reset values; no out_valid.
// TESTING
//   1 WIDTH=16,DIGIT=4: op=0, 5+3 -> out_valid 4 cycles after accept; sum=8, cout=0, ovf=0, zero=0
//   2 op=1, 3-3 -> sum=0, cout=1, overflow=0, zero=1; op=1, 4-2 -> sum=2, cout=1
//   3 op=0, 0x7FFF+0x0001 -> sum=0x8000, overflow=1, cout=0; op=1, 0-0x8000 -> sum=0x8000, ovf=1
//   4 Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored;
//     release -> IDLE, next op accepted one cycle later
//   5 Pulse rst_n low mid-RUN -> all outputs at reset values at once; no out_valid; next op correct
//   6 Sweep DIGIT in {1,4,16} with 1000 random ops vs reference model -> sum/flags match, latency=N

Source files
------------

// File: rtl/serial_add_sub_unit.sv
// serial_add_sub_unit
// Two's-complement add/subtract unit that processes DIGIT bits per clock,
// LSB digit first. It takes operands over a valid/ready handshake and holds
// the result and flags until the consumer accepts them.
// Subtraction is lhs + ~rhs + 1. The inversion is applied when operands are
// latched, and the "+1" is the initial carry. The run datapath is therefore
// a plain digit adder.
module serial_add_sub_unit #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] lhs,
  input  logic [WIDTH-1:0] rhs,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  // Number of run cycles and the digit counter sized to hold 0..N-1
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  // Operand shift registers: the digit in flight always sits in the low bits
  logic [WIDTH-1:0] r_lhs;
  logic [WIDTH-1:0] r_rhs;
  // Result is assembled by shifting finished digits in from the top
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic [DIGIT-1:0] w_a;
  logic [DIGIT-1:0] w_b;
  logic [DIGIT-1:0] w_dsum;
  logic             w_dcout;
  logic             w_cin_msb;
  logic [WIDTH-1:0] w_res_next;

  // One digit of ripple addition with carry in; returns {carry_out, sum}
  function automatic logic [DIGIT:0] digit_add(input logic [DIGIT-1:0] a,
                                               input logic [DIGIT-1:0] b,
                                               input logic             c);
    digit_add = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, c};
  endfunction

  // Digit datapath: current digit sum, carry out, carry into the digit MSB, next result
  always_comb begin
    w_a = r_lhs[DIGIT-1:0];
    w_b = r_rhs[DIGIT-1:0];
    {w_dcout, w_dsum} = digit_add(w_a, w_b, r_carry);
    // Carry into the MSB of the digit, recovered from that bit's sum equation
    w_cin_msb  = w_a[DIGIT-1] ^ w_b[DIGIT-1] ^ w_dsum[DIGIT-1];
    w_res_next = (r_res >> DIGIT) | (WIDTH'(w_dsum) << (WIDTH - DIGIT));
  end

  // Control FSM with registered handshake outputs, result and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_lhs     <= {WIDTH{1'b0}};
      r_rhs     <= {WIDTH{1'b0}};
      r_res     <= {WIDTH{1'b0}};
      r_carry   <= 1'b0;
      r_cnt     <= {CW{1'b0}};
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= {WIDTH{1'b0}};
      cout      <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_lhs    <= lhs;
            r_rhs    <= rhs ^ {WIDTH{op}};
            r_carry  <= op;
            r_cnt    <= {CW{1'b0}};
            r_res    <= {WIDTH{1'b0}};
            in_ready <= 1'b0;
            r_state  <= ST_RUN;
          end else begin
            in_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          r_lhs   <= r_lhs >> DIGIT;
          r_rhs   <= r_rhs >> DIGIT;
          r_carry <= w_dcout;
          r_res   <= w_res_next;
          r_cnt   <= r_cnt + ONE_CNT;
          if (r_cnt == LAST_CNT) begin
            sum       <= w_res_next;
            cout      <= w_dcout;
            overflow  <= w_cin_msb ^ w_dcout;
            zero      <= (w_res_next == {WIDTH{1'b0}});
            out_valid <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            out_valid <= 1'b0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub_unit.sv
// Testbench for serial_add_sub_unit. It runs three instances (DIGIT = 1, 4
// and 16) and checks them against an arithmetic reference model.
module tb_serial_add_sub_unit;

  typedef struct packed {
    logic        cout;
    logic        ovf;
    logic        zero;
    logic [15:0] sum;
  } res_t;

  logic        clk;
  logic        rst_n;
  logic [2:0]  in_valid_v;
  logic [2:0]  in_ready_v;
  logic [2:0]  op_v;
  logic [15:0] lhs_v [3];
  logic [15:0] rhs_v [3];
  logic [2:0]  out_valid_v;
  logic [2:0]  out_ready_v;
  logic [15:0] sum_v [3];
  logic [2:0]  cout_v;
  logic [2:0]  ovf_v;
  logic [2:0]  zero_v;

  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DG = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
    serial_add_sub_unit #(.WIDTH(16), .DIGIT(DG)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_v[g]),
      .in_ready  (in_ready_v[g]),
      .op        (op_v[g]),
      .lhs       (lhs_v[g]),
      .rhs       (rhs_v[g]),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready_v[g]),
      .sum       (sum_v[g]),
      .cout      (cout_v[g]),
      .overflow  (ovf_v[g]),
      .zero      (zero_v[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int digit_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 4 : 16);
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed views
  function automatic res_t model(input logic o, input logic [15:0] a, input logic [15:0] b);
    res_t r;
    int ua, ub, sa, sb, sres;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (o == 1'b0) begin
      r.sum  = a + b;
      r.cout = ((ua + ub) > 65535);
      sres   = sa + sb;
    end else begin
      r.sum  = a - b;
      r.cout = (ua >= ub);
      sres   = sa - sb;
    end
    r.ovf  = (sres > 32767) || (sres < -32768);
    r.zero = (r.sum == 16'h0000);
    return r;
  endfunction

  task automatic exec_op(input int k, input logic o, input logic [15:0] a,
                         input logic [15:0] b, input int stall);
    res_t e;
    int cyc;
    e = model(o, a, b);
    in_valid_v[k] = 1'b1;
    op_v[k] = o;
    lhs_v[k] = a;
    rhs_v[k] = b;
    checks++;
    if (in_ready_v[k] !== 1'b1) begin
      errors++; $display("FAIL accept_ready k=%0d got=%b exp=1", k, in_ready_v[k]);
    end
    @(posedge clk); #1;
    in_valid_v[k] = 1'b0;
    op_v[k] = 1'($urandom);
    lhs_v[k] = 16'($urandom);
    rhs_v[k] = 16'($urandom);
    checks++;
    if (in_ready_v[k] !== 1'b0) begin
      errors++; $display("FAIL busy_ready k=%0d got=%b exp=0", k, in_ready_v[k]);
    end
    cyc = 0;
    while (out_valid_v[k] !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc != 16 / digit_of(k)) begin
      errors++; $display("FAIL latency k=%0d got=%0d exp=%0d", k, cyc, 16 / digit_of(k));
    end
    for (int s = 0; s <= stall; s++) begin
      if (s > 0) begin
        @(posedge clk); #1;
      end
      checks++;
      if (out_valid_v[k] !== 1'b1) begin
        errors++; $display("FAIL hold_valid k=%0d got=%b exp=1", k, out_valid_v[k]);
      end
      checks++;
      if ({cout_v[k], ovf_v[k], zero_v[k], sum_v[k]} !== e) begin
        errors++;
        $display("FAIL result k=%0d op=%b a=%h b=%h got c/v/z/sum=%b%b%b/%h exp=%b%b%b/%h",
                 k, o, a, b, cout_v[k], ovf_v[k], zero_v[k], sum_v[k], e.cout, e.ovf, e.zero, e.sum);
      end
    end
    out_ready_v[k] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[k] = 1'b0;
    checks++;
    if (out_valid_v[k] !== 1'b0 || in_ready_v[k] !== 1'b1) begin
      errors++; $display("FAIL release k=%0d got valid/ready=%b%b exp=01", k, out_valid_v[k], in_ready_v[k]);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({in_ready_v[k], out_valid_v[k], cout_v[k], ovf_v[k], zero_v[k], sum_v[k]} !== {5'b10000, 16'h0000}) begin
        errors++;
        $display("FAIL reset_state k=%0d got rdy/vld/c/v/z/sum=%b%b%b%b%b/%h exp=10000/0000",
                 k, in_ready_v[k], out_valid_v[k], cout_v[k], ovf_v[k], zero_v[k], sum_v[k]);
      end
    end
  endtask

  task automatic test_add();
    exec_op(1, 1'b0, 16'd5, 16'd3, 0);
    checks++;
    if ({sum_v[1], cout_v[1], ovf_v[1], zero_v[1]} !== {16'd8, 3'b000}) begin
      errors++; $display("FAIL add_5_3 got sum=%h c/v/z=%b%b%b exp=0008/000", sum_v[1], cout_v[1], ovf_v[1], zero_v[1]);
    end
  endtask

  task automatic test_sub();
    exec_op(1, 1'b1, 16'd3, 16'd3, 0);
    checks++;
    if ({sum_v[1], cout_v[1], ovf_v[1], zero_v[1]} !== {16'd0, 3'b101}) begin
      errors++; $display("FAIL sub_3_3 got sum=%h c/v/z=%b%b%b exp=0000/101", sum_v[1], cout_v[1], ovf_v[1], zero_v[1]);
    end
    exec_op(1, 1'b1, 16'd4, 16'd2, 1);
    checks++;
    if ({sum_v[1], cout_v[1], zero_v[1]} !== {16'd2, 2'b10}) begin
      errors++; $display("FAIL sub_4_2 got sum=%h c/z=%b%b exp=0002/10", sum_v[1], cout_v[1], zero_v[1]);
    end
  endtask

  task automatic test_overflow();
    exec_op(1, 1'b0, 16'h7FFF, 16'h0001, 0);
    checks++;
    if ({sum_v[1], cout_v[1], ovf_v[1]} !== {16'h8000, 2'b01}) begin
      errors++; $display("FAIL ovf_add got sum=%h c/v=%b%b exp=8000/01", sum_v[1], cout_v[1], ovf_v[1]);
    end
    exec_op(1, 1'b1, 16'h0000, 16'h8000, 0);
    checks++;
    if ({sum_v[1], ovf_v[1]} !== {16'h8000, 1'b1}) begin
      errors++; $display("FAIL ovf_sub_minneg got sum=%h v=%b exp=8000/1", sum_v[1], ovf_v[1]);
    end
    exec_op(1, 1'b1, 16'hFFFF, 16'h8000, 0);
    checks++;
    if (ovf_v[1] !== 1'b0) begin
      errors++; $display("FAIL noovf_sub_minneg got v=%b exp=0", ovf_v[1]);
    end
  endtask

  task automatic test_stall();
    int cyc;
    in_valid_v[1] = 1'b1; op_v[1] = 1'b0; lhs_v[1] = 16'd100; rhs_v[1] = 16'd23;
    @(posedge clk); #1;
    in_valid_v[1] = 1'b0;
    cyc = 0;
    while (out_valid_v[1] !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    in_valid_v[1] = 1'b1; op_v[1] = 1'b1; lhs_v[1] = 16'd50; rhs_v[1] = 16'd8;
    for (int s = 0; s < 10; s++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid_v[1], in_ready_v[1], sum_v[1], cout_v[1], ovf_v[1], zero_v[1]} !== {2'b10, 16'd123, 3'b000}) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got vld/rdy=%b%b sum=%h c/v/z=%b%b%b exp=10/007b/000",
                 s, out_valid_v[1], in_ready_v[1], sum_v[1], cout_v[1], ovf_v[1], zero_v[1]);
      end
    end
    out_ready_v[1] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[1] = 1'b0;
    checks++;
    if ({out_valid_v[1], in_ready_v[1]} !== 2'b01) begin
      errors++; $display("FAIL stall_release got vld/rdy=%b%b exp=01", out_valid_v[1], in_ready_v[1]);
    end
    @(posedge clk); #1;
    in_valid_v[1] = 1'b0;
    checks++;
    if (in_ready_v[1] !== 1'b0) begin
      errors++; $display("FAIL stall_next_accept got rdy=%b exp=0", in_ready_v[1]);
    end
    cyc = 0;
    while (out_valid_v[1] !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (cyc != 4 || sum_v[1] !== 16'd42) begin
      errors++; $display("FAIL stall_next_result got lat=%0d sum=%h exp=4/002a", cyc, sum_v[1]);
    end
    out_ready_v[1] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[1] = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    in_valid_v[1] = 1'b1; op_v[1] = 1'b0; lhs_v[1] = 16'd7; rhs_v[1] = 16'd9;
    @(posedge clk); #1;
    in_valid_v[1] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    test_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int s = 0; s < 6; s++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid_v[1] !== 1'b0 || in_ready_v[1] !== 1'b1) begin
        errors++; $display("FAIL post_reset_idle cyc=%0d got vld/rdy=%b%b exp=01", s, out_valid_v[1], in_ready_v[1]);
      end
    end
    exec_op(1, 1'b0, 16'd1234, 16'd4321, 0);
  endtask

  task automatic test_random_sweep();
    logic [15:0] corner [6];
    logic [15:0] a, b;
    corner[0] = 16'h0000; corner[1] = 16'h0001; corner[2] = 16'h7FFF;
    corner[3] = 16'h8000; corner[4] = 16'hFFFF; corner[5] = 16'h8001;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 1000; i++) begin
        a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
        b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
        exec_op(k, 1'($urandom), a, b, int'($urandom_range(0, 2)));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid_v = 3'b000;
    op_v = 3'b000;
    out_ready_v = 3'b000;
    for (int k = 0; k < 3; k++) begin
      lhs_v[k] = 16'h0000;
      rhs_v[k] = 16'h0000;
    end
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_add();
    test_sub();
    test_overflow();
    test_stall();
    test_reset_mid_run();
    test_random_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
